// File: rtl/chip_invaders_pkg.sv
// Shared types and sprite geometry for the chip invaders game logic.
// Coordinates are 16-bit screen pixels; sprite sizes are in pixels.
package chip_invaders_pkg;

    localparam int COORD_W  = 16;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int ALIEN_W  = 32;
    localparam int ALIEN_H  = 16;
    localparam int BULLET_W = 2;
    localparam int BULLET_H = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } hit_state_e;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap test; edges that merely touch do not overlap.
// Sums are widened by one bit so boxes near the right/bottom screen edge never wrap.
module aabb_overlap
    import chip_invaders_pkg::*;
#(
    parameter int A_W = ALIEN_W,
    parameter int A_H = ALIEN_H,
    parameter int B_W = BULLET_W,
    parameter int B_H = BULLET_H
) (
    input  coord_t a_x,
    input  coord_t a_y,
    input  coord_t b_x,
    input  coord_t b_y,
    output logic   overlap
);

    typedef logic [COORD_W:0] wide_t;

    wide_t ax, ay, bx, by;

    assign ax = {1'b0, a_x};
    assign ay = {1'b0, a_y};
    assign bx = {1'b0, b_x};
    assign by = {1'b0, b_y};

    assign overlap = (bx < ax + wide_t'(A_W)) &&
                     (bx + wide_t'(B_W) > ax) &&
                     (by < ay + wide_t'(A_H)) &&
                     (by + wide_t'(B_H) > ay);

endmodule

// File: rtl/alien_hit_detector.sv
// Scans the alien formation one alien per cycle, bottom row first, and reports the
// first live alien the player bullet overlaps as a one-cycle hit pulse with its score.
module alien_hit_detector
    import chip_invaders_pkg::*;
#(
    parameter int NUM_ROWS   = 3,
    parameter int NUM_COLS   = 5,
    parameter int SCORE_BASE = 10
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      check_req,
    input  logic                                      bullet_active,
    input  coord_t                                    bullet_x,
    input  coord_t                                    bullet_y,
    input  logic   [NUM_ROWS-1:0][NUM_COLS-1:0]       alive_matrix,
    input  coord_t [NUM_ROWS-1:0][NUM_COLS-1:0]       alien_pos_x,
    input  coord_t [NUM_ROWS-1:0][NUM_COLS-1:0]       alien_pos_y,
    output logic                                      busy,
    output logic   [NUM_ROWS-1:0][NUM_COLS-1:0]       hit_signals,
    output logic                                      bullet_hit,
    output logic                                      scan_done,
    output logic   [7:0]                              score_add
);

    localparam int NUM_ALIENS = NUM_ROWS * NUM_COLS;
    localparam int IDX_W      = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1;
    localparam int ROW_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int COL_W      = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ALIENS - 1);
    localparam logic [ROW_W-1:0] BOTTOM_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);

    // Lower rows are closer to the player and therefore worth less.
    function automatic logic [7:0] row_score(input logic [ROW_W-1:0] r);
        return 8'(SCORE_BASE * (NUM_ROWS - int'(r)));
    endfunction

    hit_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    coord_t bx_q, bx_d, by_q, by_d;

    logic [NUM_ROWS-1:0][NUM_COLS-1:0] hit_d;
    logic                              bullet_hit_d;
    logic                              scan_done_d;
    logic [7:0]                        score_d;
    logic                              busy_d;

    logic overlap;
    logic alien_hit;

    aabb_overlap #(
        .A_W (ALIEN_W),
        .A_H (ALIEN_H),
        .B_W (BULLET_W),
        .B_H (BULLET_H)
    ) u_overlap (
        .a_x     (alien_pos_x[row_q][col_q]),
        .a_y     (alien_pos_y[row_q][col_q]),
        .b_x     (bx_q),
        .b_y     (by_q),
        .overlap (overlap)
    );

    assign alien_hit = alive_matrix[row_q][col_q] && overlap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            busy        <= 1'b0;
            hit_signals <= '0;
            bullet_hit  <= 1'b0;
            scan_done   <= 1'b0;
            score_add   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            busy        <= busy_d;
            hit_signals <= hit_d;
            bullet_hit  <= bullet_hit_d;
            scan_done   <= scan_done_d;
            score_add   <= score_d;
        end
    end

    // Row/col walk alongside the linear index so no divide is needed to locate alien k.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        row_d        = row_q;
        col_d        = col_q;
        bx_d         = bx_q;
        by_d         = by_q;
        hit_d        = '0;
        bullet_hit_d = 1'b0;
        scan_done_d  = 1'b0;
        score_d      = '0;

        case (state_q)
            IDLE: begin
                if (check_req && bullet_active) begin
                    state_d = SCAN;
                    bx_d    = bullet_x;
                    by_d    = bullet_y;
                    idx_d   = '0;
                    row_d   = BOTTOM_ROW;
                    col_d   = '0;
                end
            end
            SCAN: begin
                if (!bullet_active) begin
                    state_d = IDLE;
                end else if (alien_hit) begin
                    state_d              = REPORT;
                    hit_d[row_q][col_q]  = 1'b1;
                    bullet_hit_d         = 1'b1;
                    scan_done_d          = 1'b1;
                    score_d              = row_score(row_q);
                end else if (idx_q == LAST_IDX) begin
                    state_d     = REPORT;
                    scan_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q - 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_alien_hit_detector.sv
// Directed bench for alien_hit_detector: stimulus pushes expected scan results,
// an independent monitor pops and compares them whenever scan_done pulses.
module tb_alien_hit_detector;
    import chip_invaders_pkg::*;

    localparam int R = 3;
    localparam int C = 5;

    logic                     clk;
    logic                     rst;
    logic                     check_req;
    logic                     bullet_active;
    coord_t                   bullet_x;
    coord_t                   bullet_y;
    logic   [R-1:0][C-1:0]    alive_matrix;
    coord_t [R-1:0][C-1:0]    alien_pos_x;
    coord_t [R-1:0][C-1:0]    alien_pos_y;
    logic                     busy;
    logic   [R-1:0][C-1:0]    hit_signals;
    logic                     bullet_hit;
    logic                     scan_done;
    logic   [7:0]             score_add;

    typedef struct {
        int                     cyc;
        logic [R-1:0][C-1:0]    hits;
        logic                   bh;
        logic [7:0]             score;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   n;

    alien_hit_detector #(
        .NUM_ROWS   (R),
        .NUM_COLS   (C),
        .SCORE_BASE (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .check_req     (check_req),
        .bullet_active (bullet_active),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .alive_matrix  (alive_matrix),
        .alien_pos_x   (alien_pos_x),
        .alien_pos_y   (alien_pos_y),
        .busy          (busy),
        .hit_signals   (hit_signals),
        .bullet_hit    (bullet_hit),
        .scan_done     (scan_done),
        .score_add     (score_add)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Issues one check_req in the cycle after the next edge; n is the sampling cycle.
    task automatic applyStimulus(input int bx, input int by, input logic act, output int n_out);
        @(posedge clk);
        #1;
        bullet_x      = coord_t'(bx);
        bullet_y      = coord_t'(by);
        bullet_active = act;
        check_req     = 1'b1;
        n_out         = cyc;
        @(posedge clk);
        #1;
        check_req     = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic pushExp(input int at, input bit hit, input int r, input int c, input logic [7:0] score);
        exp_t e;
        e.cyc   = at;
        e.hits  = '0;
        if (hit) e.hits[r][c] = 1'b1;
        e.bh    = hit;
        e.score = score;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (scan_done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_scan_done: got scan_done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                checkOutput("hit_signals", 32'(hit_signals), 32'(mon_e.hits));
                checkOutput("bullet_hit", 32'(bullet_hit), 32'(mon_e.bh));
                checkOutput("score_add", 32'(score_add), 32'(mon_e.score));
            end
        end else if (bullet_hit || hit_signals != '0 || score_add != '0) begin
            total++;
            bad++;
            $display("[TB] FAIL stray_pulse: got hit=0x%0h bh=%0b score=%0d expected all 0 (cycle %0d)",
                     hit_signals, bullet_hit, score_add, cyc);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        check_req     = 1'b0;
        bullet_active = 1'b0;
        bullet_x      = '0;
        bullet_y      = '0;
        alive_matrix  = '1;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                alien_pos_x[r][c] = coord_t'(100 + 64 * c);
                alien_pos_y[r][c] = coord_t'(50 + 32 * r);
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_hit_signals", 32'(hit_signals), 0);
        checkOutput("reset_bullet_hit", 32'(bullet_hit), 0);
        checkOutput("reset_scan_done", 32'(scan_done), 0);
        checkOutput("reset_score_add", 32'(score_add), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] hit on row 1 col 0");
        applyStimulus(110, 84, 1'b1, n);
        pushExp(n + 7, 1'b1, 1, 0, 8'd20);
        waitUntil(n + 1);
        checkOutput("t1_busy_start", 32'(busy), 1);
        waitUntil(n + 7);
        checkOutput("t1_busy_pulse", 32'(busy), 1);
        waitUntil(n + 8);
        checkOutput("t1_busy_end", 32'(busy), 0);
        checkOutput("t1_drained", 32'(sb.size()), 0);

        $display("[TB] dead target gives a miss");
        alive_matrix[1][0] = 1'b0;
        applyStimulus(110, 84, 1'b1, n);
        pushExp(n + 16, 1'b0, 0, 0, 8'd0);
        waitUntil(n + 16);
        checkOutput("t2_busy_last", 32'(busy), 1);
        waitUntil(n + 17);
        checkOutput("t2_busy_end", 32'(busy), 0);
        checkOutput("t2_drained", 32'(sb.size()), 0);
        alive_matrix[1][0] = 1'b1;

        $display("[TB] touching edge gives a miss");
        applyStimulus(132, 84, 1'b1, n);
        pushExp(n + 16, 1'b0, 0, 0, 8'd0);
        waitUntil(n + 17);
        checkOutput("t3_drained", 32'(sb.size()), 0);

        $display("[TB] hit on row 2 col 2");
        applyStimulus(230, 116, 1'b1, n);
        pushExp(n + 4, 1'b1, 2, 2, 8'd10);
        waitUntil(n + 5);
        checkOutput("t4_busy_end", 32'(busy), 0);
        checkOutput("t4_drained", 32'(sb.size()), 0);

        $display("[TB] bullet lost mid-scan");
        applyStimulus(110, 84, 1'b1, n);
        @(posedge clk);
        #1;
        check_req = 1'b1;
        @(posedge clk);
        #1;
        check_req     = 1'b0;
        bullet_active = 1'b0;
        waitUntil(n + 3);
        checkOutput("t5_busy_before_drop", 32'(busy), 1);
        waitUntil(n + 4);
        checkOutput("t5_busy_after_drop", 32'(busy), 0);
        waitUntil(n + 20);
        checkOutput("t5_no_pulse", 32'(sb.size()), 0);

        $display("[TB] check_req with no bullet");
        applyStimulus(110, 84, 1'b0, n);
        waitUntil(n + 1);
        checkOutput("inactive_busy", 32'(busy), 0);
        waitUntil(n + 20);

        $display("[TB] reset mid-scan");
        applyStimulus(110, 84, 1'b1, n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitUntil(n + 3);
        checkOutput("t6_busy", 32'(busy), 0);
        checkOutput("t6_hit_signals", 32'(hit_signals), 0);
        checkOutput("t6_scan_done", 32'(scan_done), 0);
        waitUntil(n + 12);

        applyStimulus(230, 116, 1'b1, n);
        pushExp(n + 4, 1'b1, 2, 2, 8'd10);
        waitUntil(n + 5);
        checkOutput("t6_rescan_busy_end", 32'(busy), 0);
        checkOutput("t6_rescan_drained", 32'(sb.size()), 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
